// File: rtl/fx2_stream_writer_if.sv
// fx2_stream_writer_if
//   Groups the sample-source side (enable, src_sel, adc_*) and the FX2
//   slave-FIFO pins (fd_*, fifoadr, slwr_n, pktend_n, fx2_full_n) together
//   with the status outputs (overflow, busy).
//   master : the environment (capture logic + FX2 pins), drives inputs.
//   slave  : the stream writer.
interface fx2_stream_writer_if;
  logic        enable;
  logic        src_sel;
  logic [13:0] adc_i;
  logic [13:0] adc_q;
  logic        adc_valid;
  logic        fx2_full_n;
  logic [15:0] fd_out;
  logic        fd_oe;
  logic [1:0]  fifoadr;
  logic        slwr_n;
  logic        pktend_n;
  logic        overflow;
  logic        busy;

  modport master (
    output enable, src_sel, adc_i, adc_q, adc_valid, fx2_full_n,
    input  fd_out, fd_oe, fifoadr, slwr_n, pktend_n, overflow, busy
  );

  modport slave (
    input  enable, src_sel, adc_i, adc_q, adc_valid, fx2_full_n,
    output fd_out, fd_oe, fifoadr, slwr_n, pktend_n, overflow, busy
  );
endinterface

// File: rtl/fx2_stream_writer.sv
// fx2_stream_writer
//   Buffers ADC I/Q pairs (or a test counter pattern) in a small FIFO and
//   writes each pair as two tagged 16-bit words into the FX2 slave-FIFO IN
//   endpoint, honouring the registered full flag. Issues PKTEND to commit a
//   short packet when streaming stops.
// Ports:
//   clk  : IFCLK-domain clock
//   rst  : synchronous active-high reset
//   bus  : fx2_stream_writer_if.slave (source inputs, FX2 pins, status)
module fx2_stream_writer #(
  parameter int         DEPTH     = 16,
  parameter int         PKT_WORDS = 256,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input logic               clk,
  input logic               rst,
  fx2_stream_writer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(PKT_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WR_I, S_WR_Q, S_END} state_t;

  state_t          st, nxt;
  logic [27:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [27:0]     pair;
  logic [14:0]     tcnt;
  logic [WW-1:0]   wcnt;
  logic            full_q, enable_q, ovf;
  logic            push_req, push, pop, empty, full, wr, pkt;
  logic [27:0]     din;

  assign push_req = bus.adc_valid & bus.enable;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees a slot, so a push on a full FIFO survives.
  assign push     = push_req & (~full | pop);
  assign din      = bus.src_sel ? {tcnt[13:0], tcnt[13:0]} : {bus.adc_i, bus.adc_q};

  // Pair storage, no reset needed on the array itself.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      pair     <= '0;
      tcnt     <= '0;
      wcnt     <= '0;
      full_q   <= 1'b0;
      enable_q <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      full_q   <= bus.fx2_full_n;
      enable_q <= bus.enable;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        pair   <= mem[rd_ptr];
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      // Test counter advances on every attempted push, dropped or not.
      if (push_req && bus.src_sel) tcnt <= tcnt + 1'b1;
      if (pkt)     wcnt <= '0;
      else if (wr) wcnt <= wcnt + 1'b1;
      // Rising enable clears; a drop in the same cycle still wins.
      ovf <= (ovf & ~(bus.enable & ~enable_q)) | (push_req & ~push);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  // FSM: next state (pop is issued on the transition that loads a pair)
  always_comb begin
    nxt = st;
    pop = 1'b0;
    case (st)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          nxt = S_WR_I;
        end else if (!bus.enable && wcnt != '0) begin
          nxt = S_END;
        end
      end
      S_WR_I: if (full_q) nxt = S_WR_Q;
      S_WR_Q: begin
        // Chain straight into the next pair to keep one word per cycle.
        if (full_q) begin
          if (!empty) begin
            pop = 1'b1;
            nxt = S_WR_I;
          end else begin
            nxt = S_IDLE;
          end
        end
      end
      S_END:  if (full_q) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr          = (st == S_WR_I || st == S_WR_Q) && full_q;
    pkt         = (st == S_END) && full_q;
    bus.slwr_n  = ~wr;
    bus.pktend_n = ~pkt;
    bus.fd_oe   = (st != S_IDLE);
    bus.fifoadr = EP_ADDR;
    bus.busy    = ~empty | (st != S_IDLE);
    bus.overflow = ovf;
    case (st)
      S_WR_I:  bus.fd_out = {1'b0, pair[27], pair[27:14]};
      S_WR_Q:  bus.fd_out = {1'b1, pair[13], pair[13:0]};
      default: bus.fd_out = '0;
    endcase
  end
endmodule
